// File: rtl/cap_err_sched.sv
// cap_err_sched - multi-channel capability-error injection scheduler.
//
// Every channel (LSU, CLC/CSC, CJALR, fetch, ...) runs an IDLE -> SCHED ->
// ACTIVE FSM. A retirement on the channel evaluates a schedule decision
// (random, periodic or burst). A scheduled channel injects on its next
// qualifying candidate outside an ISR. An injected fault must be reported by
// the checker, otherwise err_failed_o pulses.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   err_enable_i   global injection enable
//   err_rate_i     3 bits per channel; 0 = off, else period/probability 2^(8-rate)
//   mode_i         00 random, 01 periodic, 10 burst, 11 treated as random
//   in_isr_i       core is in an ISR; suppresses injection
//   evt_cand_i     per channel: qualifying instruction in EX
//   evt_done_i     per channel: qualifying instruction retired
//   chk_req_i      per channel: injected instruction reached its check point
//   chk_err_i      per channel: checker flagged a cheri error (with chk_req_i)
//   inject_o       per channel: apply fault this cycle
//   seed_o         SEED_W bits per channel, fault-selection seed
//   err_active_o   OR of inject_o
//   inj_cnt_o      (CAP_ERR_SCHED_STATS_EN only) saturating injection count
//   fail_cnt_o     (CAP_ERR_SCHED_STATS_EN only) saturating failure count
//   err_failed_o   per channel: one-cycle pulse, injected fault not detected
//
// Optional build macro: CAP_ERR_SCHED_STATS_EN adds the statistics counters.
module cap_err_sched #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEED_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] LFSR_INIT = 32'hACE1_2468
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     err_enable_i,
  input  logic [3*NUM_CH-1:0]      err_rate_i,
  input  logic [1:0]               mode_i,
  input  logic                     in_isr_i,
  input  logic [NUM_CH-1:0]        evt_cand_i,
  input  logic [NUM_CH-1:0]        evt_done_i,
  input  logic [NUM_CH-1:0]        chk_req_i,
  input  logic [NUM_CH-1:0]        chk_err_i,
  output logic [NUM_CH-1:0]        inject_o,
  output logic [SEED_W*NUM_CH-1:0] seed_o,
  output logic                     err_active_o,
`ifdef CAP_ERR_SCHED_STATS_EN
  output logic [CNT_W*NUM_CH-1:0]  inj_cnt_o,
  output logic [CNT_W*NUM_CH-1:0]  fail_cnt_o,
`endif
  output logic [NUM_CH-1:0]        err_failed_o
);

  localparam logic [31:0]      LFSR_POLY = 32'h8020_0003;
  localparam int unsigned      REM_W     = $clog2(BURST_LEN + 1);
  localparam logic [REM_W-1:0] REM_INIT  = REM_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCHED  = 2'd1,
    ST_ACTIVE = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    MODE_RANDOM   = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  if ((CNT_W < 1) || (BURST_LEN < 1) || (LFSR_INIT == 32'h0)) begin : g_param_check
    $error("cap_err_sched: CNT_W and BURST_LEN must be >= 1, LFSR_INIT non-zero");
  end

  mode_e             mode;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       draw      [NUM_CH];
  ch_state_e         state_q   [NUM_CH];
  ch_state_e         state_d   [NUM_CH];
  logic [6:0]        per_cnt_q [NUM_CH];
  logic [6:0]        per_cnt_d [NUM_CH];
  logic [REM_W-1:0]  rem_q     [NUM_CH];
  logic [REM_W-1:0]  rem_d     [NUM_CH];
  logic [SEED_W-1:0] seed_q    [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] failed_q, fail_set;
  logic [NUM_CH-1:0] seed_load, hit, grant;
  logic              taken;
  logic [2:0]        rate;
  logic [7:0]        span;
  logic [6:0]        mask;
  logic              rnd_hit;

  assign mode = mode_e'(mode_i);

  function automatic logic [SEED_W-1:0] seed_of(input logic [31:0] d);
    logic [SEED_W+31:0] ext;
    ext = {{SEED_W{1'b0}}, d};
    return ext[SEED_W-1:0];
  endfunction

  // Galois LFSR (right shift); the all-zero lock-up state reloads the seed.
  always_comb begin
    if (lfsr_q == '0) begin
      lfsr_d = LFSR_INIT;
    end else begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
    end
  end

  // Per-channel draw: LFSR rotated left by 8*c.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      draw[c] = (lfsr_q << ((8 * c) % 32)) | (lfsr_q >> (32 - ((8 * c) % 32)));
    end
  end

  // Grant: ACTIVE channels always hold it; among requesting SCHED channels
  // only the lowest index may move to ACTIVE this cycle.
  always_comb begin
    grant    = '0;
    inject_o = '0;
    taken    = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (state_q[c] == ST_ACTIVE) begin
        grant[c] = 1'b1;
      end else if ((state_q[c] == ST_SCHED) && evt_cand_i[c] && !in_isr_i && !taken) begin
        grant[c] = 1'b1;
        taken    = 1'b1;
      end
      inject_o[c] = (state_q[c] != ST_IDLE) && evt_cand_i[c] && !in_isr_i && grant[c];
    end
  end

  assign err_active_o = |inject_o;

  // Schedule decision on retirement. A SCHED channel that injects in the
  // same cycle keeps the injection and skips this decision.
  always_comb begin
    hit     = '0;
    rate    = '0;
    span    = '0;
    mask    = '0;
    rnd_hit = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      per_cnt_d[c] = per_cnt_q[c];
      rem_d[c]     = rem_q[c];
      rate         = err_rate_i[3*c +: 3];
      span         = 8'd1 << (4'd8 - {1'b0, rate});
      mask         = 7'(span - 8'd1);
      rnd_hit      = (draw[c][6:0] & mask) == '0;
      if (evt_done_i[c] && err_enable_i && (rate != '0) &&
          !((state_q[c] == ST_SCHED) && inject_o[c])) begin
        case (mode)
          MODE_PERIODIC: begin
            if (per_cnt_q[c] == mask) begin
              hit[c]       = 1'b1;
              per_cnt_d[c] = '0;
            end else begin
              per_cnt_d[c] = per_cnt_q[c] + 7'd1;
            end
          end
          MODE_BURST: begin
            if (rem_q[c] != '0) begin
              hit[c]   = 1'b1;
              rem_d[c] = rem_q[c] - REM_W'(1);
            end else if (rnd_hit) begin
              hit[c]   = 1'b1;
              rem_d[c] = REM_INIT;
            end
          end
          default: hit[c] = rnd_hit;
        endcase
      end
    end
  end

  // Channel FSMs. In ACTIVE the check is resolved before a retirement closes
  // the injection, so a same-cycle check and retire both take effect.
  always_comb begin
    pend_d    = pend_q;
    fail_set  = '0;
    seed_load = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        ST_IDLE: begin
          if (evt_done_i[c]) begin
            state_d[c]   = hit[c] ? ST_SCHED : ST_IDLE;
            seed_load[c] = hit[c];
          end
        end
        ST_SCHED: begin
          if (inject_o[c]) begin
            state_d[c] = ST_ACTIVE;
            pend_d[c]  = 1'b1;
          end else if (evt_done_i[c]) begin
            state_d[c]   = hit[c] ? ST_SCHED : ST_IDLE;
            seed_load[c] = hit[c];
          end else if (!err_enable_i) begin
            state_d[c] = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (pend_q[c] && chk_req_i[c]) begin
            pend_d[c]   = 1'b0;
            fail_set[c] = !chk_err_i[c];
          end
          if (evt_done_i[c]) begin
            pend_d[c]    = 1'b0;
            state_d[c]   = hit[c] ? ST_SCHED : ST_IDLE;
            seed_load[c] = hit[c];
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_INIT;
      pend_q   <= '0;
      failed_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= ST_IDLE;
        per_cnt_q[c] <= '0;
        rem_q[c]     <= '0;
        seed_q[c]    <= '0;
      end
    end else begin
      lfsr_q   <= lfsr_d;
      pend_q   <= pend_d;
      failed_q <= fail_set;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= state_d[c];
        per_cnt_q[c] <= per_cnt_d[c];
        rem_q[c]     <= rem_d[c];
        if (seed_load[c]) begin
          seed_q[c] <= seed_of(draw[c]);
        end
      end
    end
  end

  assign err_failed_o = failed_q;

  always_comb begin
    seed_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      seed_o[c*SEED_W +: SEED_W] = seed_q[c];
    end
  end

`ifdef CAP_ERR_SCHED_STATS_EN
  logic [CNT_W-1:0] inj_cnt_q  [NUM_CH];
  logic [CNT_W-1:0] fail_cnt_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        inj_cnt_q[c]  <= '0;
        fail_cnt_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if ((state_q[c] == ST_SCHED) && inject_o[c] && (inj_cnt_q[c] != '1)) begin
          inj_cnt_q[c] <= inj_cnt_q[c] + CNT_W'(1);
        end
        if (failed_q[c] && (fail_cnt_q[c] != '1)) begin
          fail_cnt_q[c] <= fail_cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    inj_cnt_o  = '0;
    fail_cnt_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      inj_cnt_o[c*CNT_W +: CNT_W]  = inj_cnt_q[c];
      fail_cnt_o[c*CNT_W +: CNT_W] = fail_cnt_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_cap_err_sched.sv
// Directed self-checking bench for cap_err_sched (4 channels, 32-bit seeds).
module tb_cap_err_sched;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEED_W = 32;
  localparam logic [31:0] INIT   = 32'hACE1_2468;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     err_enable_i = 1'b0;
  logic [3*NUM_CH-1:0]      err_rate_i = '0;
  logic [1:0]               mode_i = '0;
  logic                     in_isr_i = 1'b0;
  logic [NUM_CH-1:0]        evt_cand_i = '0;
  logic [NUM_CH-1:0]        evt_done_i = '0;
  logic [NUM_CH-1:0]        chk_req_i = '0;
  logic [NUM_CH-1:0]        chk_err_i = '0;
  logic [NUM_CH-1:0]        inject_o;
  logic [SEED_W*NUM_CH-1:0] seed_o;
  logic                     err_active_o;
  logic [NUM_CH-1:0]        err_failed_o;
`ifdef CAP_ERR_SCHED_STATS_EN
  logic [16*NUM_CH-1:0]     inj_cnt_o;
  logic [16*NUM_CH-1:0]     fail_cnt_o;
`endif

  cap_err_sched #(
    .NUM_CH   (NUM_CH),
    .SEED_W   (SEED_W),
    .BURST_LEN(4),
    .CNT_W    (16),
    .LFSR_INIT(INIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .err_enable_i(err_enable_i),
    .err_rate_i  (err_rate_i),
    .mode_i      (mode_i),
    .in_isr_i    (in_isr_i),
    .evt_cand_i  (evt_cand_i),
    .evt_done_i  (evt_done_i),
    .chk_req_i   (chk_req_i),
    .chk_err_i   (chk_err_i),
    .inject_o    (inject_o),
    .seed_o      (seed_o),
    .err_active_o(err_active_o),
`ifdef CAP_ERR_SCHED_STATS_EN
    .inj_cnt_o   (inj_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
`endif
    .err_failed_o(err_failed_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference LFSR, advanced with the same clock and reset as the design.
  logic [31:0] lfsr_m;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s == 32'h0) return INIT;
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] v, input int c);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < c; i++) r = {r[23:0], r[31:24]};
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= INIT;
    else        lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    evt_cand_i = '0;
    evt_done_i = '0;
    chk_req_i  = '0;
    chk_err_i  = '0;
    in_isr_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One-cycle retirement; snap is the LFSR value the design decides on.
  task automatic do_done(input logic [3:0] m, output logic [31:0] snap);
    evt_done_i = m;
    snap       = lfsr_m;
    tick();
    evt_done_i = '0;
  endtask

  task automatic do_cand(input logic [3:0] m, output logic [3:0] inj, output logic act);
    evt_cand_i = m;
    @(negedge clk);
    inj = inject_o;
    act = err_active_o;
    tick();
    evt_cand_i = '0;
  endtask

  // Waits (bounded) for a cycle where channel c's draw is / is not a random hit.
  task automatic wait_draw(input string tag, input int c, input logic [31:0] mask, input bit want_hit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ((((rotl8(lfsr_m, c) & mask) == 32'h0) ? 1'b1 : 1'b0) == want_hit) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_val(tag, ok, 1);
  endtask

  task automatic do_chk(input logic [3:0] req, input logic [3:0] err,
                        output logic [3:0] f0, output logic [3:0] f1, output logic [3:0] f2);
    chk_req_i = req;
    chk_err_i = err;
    @(negedge clk);
    f0 = err_failed_o;
    tick();
    chk_req_i = '0;
    chk_err_i = '0;
    @(negedge clk);
    f1 = err_failed_o;
    tick();
    @(negedge clk);
    f2 = err_failed_o;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap, exp_s0, exp_s2;
    logic [3:0]  inj, f0, f1, f2;
    logic        act;
    int          n_inj, n_act;

    // Reset state
    #1;
    check_val("rst_inject", inject_o, 0);
    check_val("rst_active", err_active_o, 0);
    check_val("rst_failed", err_failed_o, 0);
    check_val("rst_seed", seed_o, 0);

    // rate 0 everywhere: nothing ever injects
    err_enable_i = 1'b1;
    mode_i       = 2'b00;
    err_rate_i   = '0;
    apply_reset();
    n_inj = 0;
    n_act = 0;
    for (int i = 0; i < 200; i++) begin
      evt_done_i = '1;
      evt_cand_i = '1;
      @(negedge clk);
      if (inject_o != '0) n_inj++;
      if (err_active_o) n_act++;
      tick();
    end
    evt_done_i = '0;
    evt_cand_i = '0;
    check_val("rate0_inject", n_inj, 0);
    check_val("rate0_active", n_act, 0);

    // periodic, ch0 rate 5 -> every 8th event
    mode_i     = 2'b01;
    err_rate_i = 12'h005;
    apply_reset();
    n_inj = 0;
    for (int i = 1; i <= 32; i++) begin
      do_done(4'b0001, snap);
      exp_s0 = snap;
      do_cand(4'b0001, inj, act);
      check_val("per_inj", inj, ((i % 8) == 0) ? 4'b0001 : 4'b0000);
      if (inj[0]) begin
        n_inj++;
        check_val("per_seed", seed_o[31:0], exp_s0);
      end
    end
    check_val("per_count", n_inj, 4);

    // burst, ch1 rate 4: one random hit gives four consecutive injections
    mode_i     = 2'b10;
    err_rate_i = 12'h020;
    apply_reset();
    wait_draw("burst_wait_hit", 1, 32'hF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_done(4'b0010, snap);
      exp_s0 = rotl8(snap, 1);
      check_val("burst_seed", seed_o[63:32], exp_s0);
      do_cand(4'b0010, inj, act);
      check_val("burst_inj", inj, 4'b0010);
    end
    wait_draw("burst_wait_miss", 1, 32'hF, 1'b0);
    do_done(4'b0010, snap);
    do_cand(4'b0010, inj, act);
    check_val("burst_resume_inj", inj, 4'b0000);
    check_val("burst_resume_seed", seed_o[63:32], exp_s0);

    // random and reserved mode, ch3 rate 4
    err_rate_i = 12'h800;
    for (int m = 0; m < 2; m++) begin
      mode_i = (m == 0) ? 2'b00 : 2'b11;
      apply_reset();
      wait_draw("rnd_wait_hit", 3, 32'hF, 1'b1);
      do_done(4'b1000, snap);
      check_val("rnd_seed", seed_o[127:96], rotl8(snap, 3));
      do_cand(4'b1000, inj, act);
      check_val("rnd_hit_inj", inj, 4'b1000);
      wait_draw("rnd_wait_miss", 3, 32'hF, 1'b0);
      do_done(4'b1000, snap);
      do_cand(4'b1000, inj, act);
      check_val("rnd_miss_inj", inj, 4'b0000);
    end

    // grant: ch0 and ch2 scheduled together (periodic rate 7 -> period 2)
    mode_i     = 2'b01;
    err_rate_i = 12'h1C7;
    apply_reset();
    do_done(4'b0101, snap);
    do_done(4'b0101, snap);
    exp_s0 = snap;
    exp_s2 = rotl8(snap, 2);
    do_cand(4'b0101, inj, act);
    check_val("grant_both_inj", inj, 4'b0001);
    check_val("grant_both_act", act, 1);
    do_cand(4'b0100, inj, act);
    check_val("grant_ch2_inj", inj, 4'b0100);
    check_val("grant_seed0", seed_o[31:0], exp_s0);
    check_val("grant_seed2", seed_o[95:64], exp_s2);

    // checker: undetected fault pulses once, detected fault does not
    err_rate_i = 12'h038;
    apply_reset();
    do_done(4'b0010, snap);
    do_done(4'b0010, snap);
    do_cand(4'b0010, inj, act);
    check_val("chk_inj", inj, 4'b0010);
    do_chk(4'b0010, 4'b0000, f0, f1, f2);
    check_val("chk_fail_now", f0, 4'b0000);
    check_val("chk_fail_pulse", f1, 4'b0010);
    check_val("chk_fail_end", f2, 4'b0000);
    do_chk(4'b0010, 4'b0000, f0, f1, f2);
    check_val("chk_once", f0 | f1 | f2, 4'b0000);
    do_done(4'b0010, snap);
    do_done(4'b0010, snap);
    do_cand(4'b0010, inj, act);
    check_val("chk2_inj", inj, 4'b0010);
    do_chk(4'b0010, 4'b0010, f0, f1, f2);
    check_val("chk_detected", f0 | f1 | f2, 4'b0000);

    // enable drop while scheduled: the schedule is discarded
    err_rate_i = 12'h007;
    apply_reset();
    do_done(4'b0001, snap);
    do_done(4'b0001, snap);
    err_enable_i = 1'b0;
    tick();
    err_enable_i = 1'b1;
    do_cand(4'b0001, inj, act);
    check_val("enable_drop_inj", inj, 4'b0000);

    // ISR defers a scheduled fault
    apply_reset();
    do_done(4'b0001, snap);
    do_done(4'b0001, snap);
    in_isr_i = 1'b1;
    do_cand(4'b0001, inj, act);
    check_val("isr_inj", inj, 4'b0000);
    check_val("isr_act", act, 0);
    in_isr_i = 1'b0;
    do_cand(4'b0001, inj, act);
    check_val("isr_exit_inj", inj, 4'b0001);

    // reset while ACTIVE with a failing check in flight
    evt_cand_i = 4'b0001;
    chk_req_i  = 4'b0001;
    chk_err_i  = 4'b0000;
    @(negedge clk);
    check_val("mid_pre_inj", inject_o, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_inj", inject_o, 0);
    check_val("mid_act", err_active_o, 0);
    check_val("mid_seed", seed_o, 0);
    check_val("mid_failed", err_failed_o, 0);
    @(negedge clk);
    check_val("mid_no_pulse", err_failed_o, 0);
    evt_cand_i = '0;
    chk_req_i  = '0;
    mode_i     = 2'b00;
    err_rate_i = 12'h007;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_done(4'b0001, snap);
    check_val("post_rst_seed", seed_o[31:0], 32'hACE1_2468);
    do_cand(4'b0001, inj, act);
    check_val("post_rst_inj", inj, 4'b0001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cap_err_sched.md
Name: cap_err_sched

Overview:
- Parametrised, multi-channel capability-error injection scheduler for the CHERIoT DV testbench.
- Per channel (e.g. RV32 LSU, CLC/CSC, CJALR, fetch), it decides pseudo-randomly, periodically or in bursts which retired-instruction slot gets an injected capability fault.
- Drives a per-channel inject strobe plus a latched seed to testbench force logic, and checks that the checker flagged each injected fault.
- Pure port-based; contains no hierarchical references.

Parameters:
NUM_CH, 4, number of independent injection channels
SEED_W, 32, width of the per-channel seed delivered with each injection
BURST_LEN, 4, injections per burst in burst mode (>=1)
CNT_W, 16, width of statistics counters
LFSR_INIT, 32'hACE1_2468, LFSR reset value (must be non-zero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
err_enable_i  in  1  global injection enable
err_rate_i  in  3*NUM_CH  per-channel rate; 0=off, else period/probability 2^(8-rate)
mode_i  in  2  00 random, 01 periodic, 10 burst, 11 reserved (treated as random)
in_isr_i  in  1  core executing ISR; suppresses injection
evt_cand_i  in  NUM_CH  qualifying instruction of channel c is in EX this cycle
evt_done_i  in  NUM_CH  qualifying instruction of channel c retired this cycle
chk_req_i  in  NUM_CH  injected instruction reached its check point (LSU req / jump)
chk_err_i  in  NUM_CH  checker raised a cheri error for channel c (valid with chk_req_i)
inject_o  out  NUM_CH  apply fault to channel c this cycle
seed_o  out  SEED_W*NUM_CH  seed for channel c fault selection, stable while scheduled/active
err_active_o  out  1  OR of inject_o
err_failed_o  out  NUM_CH  one-cycle pulse: injected fault not detected

Behaviour:
- Reset: all channel FSMs IDLE; inject_o=0; err_failed_o=0; seed_o=0; LFSR=LFSR_INIT; period/burst counters=0.
- LFSR:
  - 32-bit Galois, polynomial 0x80200003, advances every cycle.
  - If the state ever reaches 0, reload LFSR_INIT next cycle.
  - Channel c draw = LFSR rotated left by 8*c.
- Per-channel FSM: IDLE -> SCHED -> ACTIVE -> IDLE.
- Schedule decision, evaluated on evt_done_i[c] in any state (retire also closes ACTIVE):
  - hit=0 if ~err_enable_i or rate==0.
  - random: hit when low (8-rate) bits of draw are all zero.
  - periodic: per-channel event counter; hit when counter == 2^(8-rate)-1; counter then wraps to 0, else increments.
  - burst: burst_rem>0 gives hit and decrements; otherwise random rule, and a random hit loads burst_rem=BURST_LEN-1.
  - hit -> SCHED, seed_o[c] <= draw[SEED_W-1:0] (zero-extend if SEED_W>32); no hit -> IDLE.
- Injection:
  - inject_o[c] is combinational: state!=IDLE & evt_cand_i[c] & ~in_isr_i & grant[c].
  - SCHED with inject -> ACTIVE next cycle; inject_o stays asserted in ACTIVE while evt_cand_i[c].
  - Grant: at most one channel may transition SCHED->ACTIVE per cycle, lowest index wins; losers stay SCHED.
  - An ACTIVE channel always holds grant.
- SCHED with in_isr_i: remain SCHED. The fault is deferred, not dropped.
- Checking, in ACTIVE:
  - On the first chk_req_i[c] with chk_err_i[c]=0, err_failed_o[c] pulses (registered, 1 cycle later), once per injection.
  - chk_err_i=1 clears the pending check.
- Simultaneous evt_done_i[c] and chk_req_i[c]: the check is evaluated first, then the schedule.
- err_enable_i deassert: SCHED channels -> IDLE next cycle; ACTIVE channels complete normally.
- Reset mid-operation: immediate return to reset values; no err_failed pulse is generated.

Optional Feature:
- Macro CAP_ERR_SCHED_STATS_EN.
- Defined: adds ports inj_cnt_o, fail_cnt_o (CNT_W*NUM_CH each, out). They count SCHED->ACTIVE transitions and err_failed pulses per channel, saturate at all-ones, and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- rate=0 on all channels, 200 evt_done/evt_cand per channel -> inject_o never asserts; err_active_o=0.
- mode=01, rate=5 (period 8), ch0 only, 32 events -> exactly 4 injections on events 8,16,24,32; counters wrap.
- mode=10, BURST_LEN=4, force random hit on ch1 -> the next 4 ch1 candidates are injected consecutively, then randomness resumes.
- ch0 and ch2 both SCHED with evt_cand in the same cycle -> ch0 injects; ch2 injects on its next candidate; seeds unchanged.
- Injected ch1 with chk_req_i=1, chk_err_i=0 -> err_failed_o[1] single pulse 1 cycle later; with chk_err_i=1 -> no pulse.
- in_isr_i=1 during a SCHED candidate -> no inject; after ISR exit the next candidate injects. rst_n low while ACTIVE -> all outputs 0 at once, LFSR=LFSR_INIT.
